// File: rtl/chunked_serial_adder_if.sv
// Operand/result handshake bundle for chunked_serial_adder.
// master drives operands and result acceptance; slave is the adder.
interface chunked_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    // Operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;

    // Result side
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output sub,
        output out_ready,
        input  in_ready,
        input  sum,
        input  cout,
        input  overflow,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  sub,
        input  out_ready,
        output in_ready,
        output sum,
        output cout,
        output overflow,
        output out_valid
    );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice is reused NCH
// times with a registered inter-chunk carry. Valid/ready on both sides.
module chunked_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chunked_serial_adder_if.slave bus
);
    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SW    = CHUNK + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base_c;
    logic [CHUNK-1:0] a_l_c;
    logic [CHUNK-1:0] b_l_c;
    logic [SW-1:0]    slice_c;
    logic             msb_cin_c;
    logic             last_c;

    // Ripple slice on the chunk selected by idx; msb_cin_c is the carry into its top bit
    always_comb begin
        base_c    = 32'(idx_q) * CHUNK;
        a_l_c     = a_q[base_c +: CHUNK];
        b_l_c     = b_q[base_c +: CHUNK];
        slice_c   = SW'(a_l_c) + SW'(b_l_c) + SW'(carry_q);
        msb_cin_c = a_l_c[CHUNK-1] ^ b_l_c[CHUNK-1] ^ slice_c[CHUNK-1];
        last_c    = (idx_q == IDX_W'(NCH - 1));
    end

    // Next-state and datapath update; subtraction stores ~b and seeds the carry with 1
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base_c +: CHUNK] = slice_c[CHUNK-1:0];
                carry_d                = slice_c[CHUNK];
                idx_d                  = idx_q + IDX_W'(1);
                if (last_c) begin
                    cout_d  = slice_c[CHUNK];
                    ovf_d   = msb_cin_c ^ slice_c[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode the registered state; results come straight from registers
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench: three builds (CHUNK=4, 16, 1) at WIDTH=16.
module tb_chunked_serial_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        string       nm;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] ta;
    logic [15:0] tbv;
    logic        tcin;
    logic        tsub;

    logic        iv   [3];
    logic        ordy [3];
    logic        rdy  [3];
    logic        ov   [3];
    logic [15:0] sm   [3];
    logic        co   [3];
    logic        of   [3];

    int          lat_exp [3];
    int          tests;
    int          fails;
    vec_t        vecs [9];
    logic        got_m;
    int          lat_m;

    chunked_serial_adder_if #(.WIDTH(16)) bus0 ();
    chunked_serial_adder_if #(.WIDTH(16)) bus1 ();
    chunked_serial_adder_if #(.WIDTH(16)) bus2 ();

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus0));
    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    chunked_serial_adder #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.a = ta;   assign bus0.b = tbv; assign bus0.cin = tcin; assign bus0.sub = tsub;
    assign bus1.a = ta;   assign bus1.b = tbv; assign bus1.cin = tcin; assign bus1.sub = tsub;
    assign bus2.a = ta;   assign bus2.b = tbv; assign bus2.cin = tcin; assign bus2.sub = tsub;
    assign bus0.in_valid = iv[0]; assign bus0.out_ready = ordy[0];
    assign bus1.in_valid = iv[1]; assign bus1.out_ready = ordy[1];
    assign bus2.in_valid = iv[2]; assign bus2.out_ready = ordy[2];

    assign rdy[0] = bus0.in_ready; assign ov[0] = bus0.out_valid; assign sm[0] = bus0.sum;
    assign co[0]  = bus0.cout;     assign of[0] = bus0.overflow;
    assign rdy[1] = bus1.in_ready; assign ov[1] = bus1.out_valid; assign sm[1] = bus1.sum;
    assign co[1]  = bus1.cout;     assign of[1] = bus1.overflow;
    assign rdy[2] = bus2.in_ready; assign ov[2] = bus2.out_valid; assign sm[2] = bus2.sum;
    assign co[2]  = bus2.cout;     assign of[2] = bus2.overflow;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One full operation on DUT s with out_ready held high; inputs are scrambled while in flight
    task automatic run_op(input int s, input vec_t v);
        logic got;
        int   lat;
        @(negedge clk);
        chk($sformatf("%s[%0d] in_ready", v.nm, s), 32'(rdy[s]), 32'd1);
        ta = v.a; tbv = v.b; tcin = v.cin; tsub = v.sub;
        iv[s] = 1'b1; ordy[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
        ta = ~v.a; tbv = ~v.b; tcin = ~v.cin; tsub = ~v.sub;
        got = 1'b0; lat = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk); #1;
            if (ov[s]) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk($sformatf("%s[%0d] out_valid", v.nm, s), 32'(got), 32'd1);
        chk($sformatf("%s[%0d] latency", v.nm, s), 32'(lat), 32'(lat_exp[s]));
        chk($sformatf("%s[%0d] sum", v.nm, s), 32'(sm[s]), 32'(v.sum));
        chk($sformatf("%s[%0d] cout", v.nm, s), 32'(co[s]), 32'(v.cout));
        chk($sformatf("%s[%0d] overflow", v.nm, s), 32'(of[s]), 32'(v.ovf));
        @(posedge clk); #1;
        chk($sformatf("%s[%0d] consumed", v.nm, s), 32'(ov[s]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0;
        lat_exp[0] = 4; lat_exp[1] = 1; lat_exp[2] = 16;
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, "add_basic"};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap"};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf"};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"};
        vecs[5] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, "add_cin"};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_negovf"};
        vecs[7] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_zero"};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "add_all1"};

        rst_n = 1'b0;
        ta = '0; tbv = '0; tcin = 1'b0; tsub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(rdy[0]), 32'd1);
        chk("reset out_valid", 32'(ov[0]), 32'd0);
        chk("reset sum", 32'(sm[0]), 32'd0);
        chk("reset cout", 32'(co[0]), 32'd0);
        chk("reset overflow", 32'(of[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of directed vectors on the CHUNK=4 build
        for (int i = 0; i < 9; i++) begin
            run_op(0, vecs[i]);
        end

        // Single-chunk and bit-serial builds
        run_op(1, vecs[0]);
        run_op(2, vecs[0]);
        run_op(1, vecs[4]);
        run_op(2, vecs[2]);

        // Backpressure: result held in DONE while inputs wiggle
        @(negedge clk);
        ta = 16'h7FFF; tbv = 16'h0001; tcin = 1'b0; tsub = 1'b0;
        iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        got_m = 1'b0;
        for (int k = 1; k <= 40 && !got_m; k++) begin
            @(posedge clk); #1;
            if (ov[0]) got_m = 1'b1;
        end
        chk("bp out_valid", 32'(got_m), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ta    = 16'(k * 32'h1111 + 3);
            tbv   = ~ta;
            tsub  = ~tsub;
            iv[0] = ~iv[0];
            @(posedge clk); #1;
            chk($sformatf("bp%0d sum", k), 32'(sm[0]), 32'h8000);
            chk($sformatf("bp%0d cout", k), 32'(co[0]), 32'd0);
            chk($sformatf("bp%0d overflow", k), 32'(of[0]), 32'd1);
            chk($sformatf("bp%0d in_ready", k), 32'(rdy[0]), 32'd0);
            chk($sformatf("bp%0d out_valid", k), 32'(ov[0]), 32'd1);
        end
        // Release with in_valid high: not accepted in the consuming cycle
        @(negedge clk);
        ordy[0] = 1'b1; iv[0] = 1'b1;
        ta = 16'h0001; tbv = 16'h0001; tsub = 1'b0; tcin = 1'b0;
        @(posedge clk); #1;
        chk("release out_valid", 32'(ov[0]), 32'd0);
        chk("release in_ready", 32'(rdy[0]), 32'd1);
        @(posedge clk); #1;
        chk("next accept in_ready", 32'(rdy[0]), 32'd0);
        iv[0] = 1'b0;
        got_m = 1'b0; lat_m = 0;
        for (int k = 1; k <= 40 && !got_m; k++) begin
            @(posedge clk); #1;
            if (ov[0]) begin
                got_m = 1'b1;
                lat_m = k;
            end
        end
        chk("next op latency", 32'(lat_m), 32'd4);
        chk("next op sum", 32'(sm[0]), 32'h0002);
        @(posedge clk); #1;

        // Leave cout/overflow set, then reset after the second chunk of a new op
        run_op(0, vecs[6]);
        @(negedge clk);
        ta = 16'h1234; tbv = 16'h0FFF; tsub = 1'b0; tcin = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrun busy", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrun reset out_valid", 32'(ov[0]), 32'd0);
        chk("midrun reset in_ready", 32'(rdy[0]), 32'd1);
        chk("midrun reset sum", 32'(sm[0]), 32'd0);
        chk("midrun reset cout", 32'(co[0]), 32'd0);
        chk("midrun reset overflow", 32'(of[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "post_reset"});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
